// File: rtl/bsg_cache_sbuf_drain_pkg.sv
// Shared types for the store-buffer drain path: sbuf head-entry layout, drain FSM states,
// and the data-SRAM row width helper.
package bsg_cache_pkg;

    localparam int addr_width_lp            = 39;
    localparam int data_width_lp            = 64;
    localparam int ways_lp                  = 8;
    localparam int sets_lp                  = 128;
    localparam int block_size_in_words_lp   = 8;
    localparam int mask_width_lp            = data_width_lp / 8;
    localparam int way_id_width_lp          = $clog2(ways_lp);

    // Row = {set_index, word_offset}.
    function automatic int dmem_row_width(input int sets, input int words);
        return $clog2(sets * words);
    endfunction

    localparam int dmem_row_width_lp = dmem_row_width(sets_lp, block_size_in_words_lp);

    typedef struct packed {
        logic [addr_width_lp-1:0]   addr;
        logic [data_width_lp-1:0]   data;
        logic [mask_width_lp-1:0]   mask;
        logic [way_id_width_lp-1:0] way_id;
    } sbuf_entry_s;

    typedef enum logic [1:0] {
        e_idle,
        e_force,
        e_flush,
        e_done
    } drain_state_e;

endpackage

// File: rtl/bsg_cache_sbuf_drain_if.sv
// Bundle between the sbuf drain block and its neighbours (store buffer, tag-lookup, data SRAM).
// master = the drain block, slave = everything around it.
interface bsg_cache_sbuf_drain_if;
    import bsg_cache_pkg::*;

    sbuf_entry_s                                  sbuf_entry_i;
    logic                                         sbuf_v_i;
    logic                                         sbuf_yumi_o;
    logic                                         sbuf_empty_i;
    logic                                         tl_dmem_v_i;
    logic                                         flush_i;
    logic                                         flush_done_o;
    logic                                         stall_o;
    logic                                         dmem_v_o;
    logic [dmem_row_width_lp-1:0]                 dmem_addr_o;
    logic [data_width_lp*ways_lp-1:0]             dmem_data_o;
    logic [mask_width_lp*ways_lp-1:0]             dmem_mask_o;

    modport master (
        input  sbuf_entry_i, sbuf_v_i, sbuf_empty_i, tl_dmem_v_i, flush_i,
        output sbuf_yumi_o, flush_done_o, stall_o,
               dmem_v_o, dmem_addr_o, dmem_data_o, dmem_mask_o
    );

    modport slave (
        output sbuf_entry_i, sbuf_v_i, sbuf_empty_i, tl_dmem_v_i, flush_i,
        input  sbuf_yumi_o, flush_done_o, stall_o,
               dmem_v_o, dmem_addr_o, dmem_data_o, dmem_mask_o
    );

endinterface

// File: rtl/bsg_cache_sbuf_drain_expand.sv
// Spreads one store word across all ways and places its byte mask in the target way's lane.
// Purely combinational.
module bsg_cache_sbuf_drain_expand #(
    parameter int data_width_p = 64,
    parameter int ways_p       = 8,
    localparam int mask_w_lp   = data_width_p / 8,
    localparam int way_w_lp    = $clog2(ways_p)
) (
    input  logic [way_w_lp-1:0]            way_id_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [mask_w_lp-1:0]           mask_i,
    output logic [data_width_p*ways_p-1:0] dmem_data_o,
    output logic [mask_w_lp*ways_p-1:0]    dmem_mask_o
);

    assign dmem_data_o = {ways_p{data_i}};
    assign dmem_mask_o = {{((ways_p-1)*mask_w_lp){1'b0}}, mask_i} << (mask_w_lp * way_id_i);

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// Writes the store-buffer head into the data SRAM in cycles the tag-lookup stage leaves free,
// with zero-latency pop; stalls upstream on starvation and runs flush-until-empty for miss/fence.
module bsg_cache_sbuf_drain
    import bsg_cache_pkg::*;
#(
    parameter int addr_width_p          = addr_width_lp,
    parameter int data_width_p          = data_width_lp,
    parameter int ways_p                = ways_lp,
    parameter int sets_p                = sets_lp,
    parameter int block_size_in_words_p = block_size_in_words_lp,
    parameter int starve_limit_p        = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bsg_cache_sbuf_drain_if.master io
);

    localparam int row_w_lp  = dmem_row_width(sets_p, block_size_in_words_p);
    localparam int off_w_lp  = $clog2(data_width_p / 8);
    localparam int cnt_w_lp  = $clog2(starve_limit_p) + 1;
    localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

    drain_state_e          state_r, state_n;
    logic [cnt_w_lp-1:0]   starve_cnt_r, starve_cnt_n;
    logic                  stall_r;
    logic                  drain;
    logic [addr_width_p-1:0] addr;
    logic                  unused_addr_bits;

    // The SRAM port belongs to tag-lookup whenever it asks, even while we stall it.
    assign drain = io.sbuf_v_i & ~io.tl_dmem_v_i & ~reset_i;

    assign io.dmem_v_o     = drain;
    assign io.sbuf_yumi_o  = drain;
    assign io.stall_o      = stall_r;
    assign io.flush_done_o = (state_r == e_done);

    assign addr             = io.sbuf_entry_i.addr;
    assign io.dmem_addr_o   = addr[off_w_lp +: row_w_lp];
    assign unused_addr_bits = ^{addr[addr_width_p-1:off_w_lp+row_w_lp], addr[off_w_lp-1:0]};

    bsg_cache_sbuf_drain_expand #(
        .data_width_p (data_width_p),
        .ways_p       (ways_p)
    ) expand (
        .way_id_i    (io.sbuf_entry_i.way_id),
        .data_i      (io.sbuf_entry_i.data),
        .mask_i      (io.sbuf_entry_i.mask),
        .dmem_data_o (io.dmem_data_o),
        .dmem_mask_o (io.dmem_mask_o)
    );

    // Only blocked cycles the pipeline was not told to avoid count toward starvation.
    always_comb begin
        starve_cnt_n = starve_cnt_r;
        if (drain || !io.sbuf_v_i) begin
            starve_cnt_n = '0;
        end else if (io.tl_dmem_v_i && !stall_r && (starve_cnt_r != limit_lp)) begin
            starve_cnt_n = starve_cnt_r + 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_idle: begin
                if (io.flush_i) begin
                    state_n = e_flush;
                end else if (starve_cnt_n == limit_lp) begin
                    state_n = e_force;
                end
            end
            e_force: begin
                if (drain || !io.sbuf_v_i) begin
                    state_n = io.flush_i ? e_flush : e_idle;
                end
            end
            e_flush: begin
                if (io.sbuf_empty_i && !drain) begin
                    state_n = e_done;
                end
            end
            e_done: begin
                state_n = e_idle;
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            starve_cnt_r <= '0;
            stall_r      <= 1'b0;
        end else begin
            state_r      <= state_n;
            starve_cnt_r <= starve_cnt_n;
            stall_r      <= (state_n == e_force) || (state_n == e_flush);
        end
    end

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// Directed self-checking bench for bsg_cache_sbuf_drain: drain, priority, starvation, flush, reset.
module tb_bsg_cache_sbuf_drain;
    import bsg_cache_pkg::*;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    bsg_cache_sbuf_drain_if dif ();

    bsg_cache_sbuf_drain dut (
        .clk_i   (clk),
        .reset_i (reset),
        .io      (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic sbuf_entry_s mk_entry(input logic [38:0] a, input logic [63:0] d,
                                             input logic [7:0] m, input logic [2:0] w);
        sbuf_entry_s e;
        e.addr   = a;
        e.data   = d;
        e.mask   = m;
        e.way_id = w;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        dif.sbuf_entry_i = '0;
        dif.sbuf_v_i     = 1'b1;
        dif.sbuf_empty_i = 1'b0;
        dif.tl_dmem_v_i  = 1'b0;
        dif.flush_i      = 1'b0;

        // reset state, drain gated off by reset
        #3;
        check("rst_dmem_v", dif.dmem_v_o, 0);
        check("rst_yumi", dif.sbuf_yumi_o, 0);
        check("rst_stall", dif.stall_o, 0);
        check("rst_done", dif.flush_done_o, 0);
        check("rst_cnt", dut.starve_cnt_r, 0);
        dif.sbuf_v_i = 1'b0;
        @(negedge clk) reset = 1'b0;
        cyc();

        // plain drain
        d = 64'hDEADBEEF_CAFEF00D;
        dif.sbuf_entry_i = mk_entry(39'h00_0000_1238, d, 8'hFF, 3'd5);
        dif.sbuf_v_i     = 1'b1;
        #1;
        check("plain_dmem_v", dif.dmem_v_o, 1);
        check("plain_yumi", dif.sbuf_yumi_o, 1);
        check("plain_addr", dif.dmem_addr_o, 10'h247);
        check("plain_mask", dif.dmem_mask_o, 64'h0000FF00_00000000);
        check("plain_data", dif.dmem_data_o, {8{d}});
        cyc();
        dif.sbuf_v_i = 1'b0;

        // tag-lookup priority for 3 cycles, then release
        for (int i = 0; i < 3; i++) begin
            dif.sbuf_v_i    = 1'b1;
            dif.tl_dmem_v_i = 1'b1;
            #1;
            check("prio_dmem_v", dif.dmem_v_o, 0);
            check("prio_yumi", dif.sbuf_yumi_o, 0);
            check("prio_stall", dif.stall_o, 0);
            cyc();
        end
        check("prio_cnt3", dut.starve_cnt_r, 3);
        dif.tl_dmem_v_i = 1'b0;
        #1;
        check("prio_release_dmem_v", dif.dmem_v_o, 1);
        cyc();
        check("prio_cnt0", dut.starve_cnt_r, 0);

        // starvation: stall from cycle 5, tl still wins while stalled
        dif.tl_dmem_v_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check("starve_stall", dif.stall_o, (c >= 5) ? 1 : 0);
            check("starve_dmem_v", dif.dmem_v_o, 0);
            cyc();
        end
        check("starve_cnt_hold", dut.starve_cnt_r, 4);
        dif.tl_dmem_v_i = 1'b0;
        #1;
        check("starve_drain", dif.dmem_v_o, 1);
        check("starve_drain_stall", dif.stall_o, 1);
        cyc();
        dif.sbuf_v_i = 1'b0;
        #1;
        check("starve_unstall", dif.stall_o, 0);
        cyc();

        // flush with two entries
        dif.flush_i = 1'b1;
        #1;
        check("fl2_c0_stall", dif.stall_o, 0);
        cyc();
        dif.sbuf_v_i     = 1'b1;
        dif.sbuf_entry_i = mk_entry(39'h40, 64'h1122334455667788, 8'h0F, 3'd0);
        #1;
        check("fl2_c1_dmem_v", dif.dmem_v_o, 1);
        check("fl2_c1_stall", dif.stall_o, 1);
        check("fl2_c1_addr", dif.dmem_addr_o, 10'h008);
        check("fl2_c1_mask", dif.dmem_mask_o, 64'h0F);
        cyc();
        dif.sbuf_entry_i = mk_entry(39'h3FF8, 64'h0, 8'h80, 3'd7);
        #1;
        check("fl2_c2_dmem_v", dif.dmem_v_o, 1);
        check("fl2_c2_stall", dif.stall_o, 1);
        check("fl2_c2_addr", dif.dmem_addr_o, 10'h3FF);
        check("fl2_c2_mask", dif.dmem_mask_o, 64'h80000000_00000000);
        check("fl2_c2_done", dif.flush_done_o, 0);
        cyc();
        dif.sbuf_v_i     = 1'b0;
        dif.sbuf_empty_i = 1'b1;
        #1;
        check("fl2_c3_stall", dif.stall_o, 1);
        check("fl2_c3_dmem_v", dif.dmem_v_o, 0);
        check("fl2_c3_done", dif.flush_done_o, 0);
        cyc();
        check("fl2_c4_done", dif.flush_done_o, 1);
        check("fl2_c4_stall", dif.stall_o, 0);
        dif.flush_i = 1'b0;
        cyc();
        check("fl2_c5_done", dif.flush_done_o, 0);

        // flush while already empty
        dif.flush_i = 1'b1;
        #1;
        check("fle_c0_done", dif.flush_done_o, 0);
        cyc();
        check("fle_c1_done", dif.flush_done_o, 0);
        check("fle_c1_stall", dif.stall_o, 1);
        check("fle_c1_dmem_v", dif.dmem_v_o, 0);
        cyc();
        check("fle_c2_done", dif.flush_done_o, 1);
        check("fle_c2_dmem_v", dif.dmem_v_o, 0);
        dif.flush_i = 1'b0;
        cyc();
        check("fle_c3_done", dif.flush_done_o, 0);

        // async reset in the middle of a flush
        dif.sbuf_empty_i = 1'b0;
        dif.flush_i      = 1'b1;
        cyc();
        check("rstfl_stall_before", dif.stall_o, 1);
        #2;
        reset = 1'b1;
        dif.sbuf_v_i = 1'b1;
        #1;
        check("rstfl_stall", dif.stall_o, 0);
        check("rstfl_done", dif.flush_done_o, 0);
        check("rstfl_dmem_v", dif.dmem_v_o, 0);
        dif.flush_i      = 1'b0;
        dif.sbuf_v_i     = 1'b0;
        dif.sbuf_empty_i = 1'b1;
        @(negedge clk) reset = 1'b0;
        cyc();
        for (int i = 0; i < 4; i++) begin
            check("rstfl_no_done", dif.flush_done_o, 0);
            check("rstfl_no_stall", dif.stall_o, 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bsg_cache_sbuf_drain.md
Name: bsg_cache_sbuf_drain

Overview:
- Downstream consumer of the cache store buffer's head entry (sbuf_entry_o/v_o/yumi_i).
- Writes the head entry into the data SRAM in cycles when the tag-lookup stage is not reading it. The data SRAM has one port and its reads take priority.
- Prevents drain starvation by stalling the upstream pipeline.
- Provides a flush-until-empty handshake, used by the miss handler and by fence operations.

Parameters:
- addr_width_p, 39, byte address width.
- data_width_p, 64, word width.
- ways_p, 8, associativity.
- sets_p, 128, sets per way.
- block_size_in_words_p, 8, words per cache block.
- starve_limit_p, 4, consecutive blocked cycles before a forced drain.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset.
- sbuf_entry_i  in  114  head entry. Fields, MSB to LSB: addr[38:0] = [113:75], data = [74:11], mask = [10:3], way_id = [2:0].
- sbuf_v_i  in  1  head entry valid.
- sbuf_yumi_o  out  1  head entry consumed this cycle.
- sbuf_empty_i  in  1  store buffer holds nothing.
- tl_dmem_v_i  in  1  tag-lookup stage reads the data SRAM this cycle.
- flush_i  in  1  request to drain until empty; level, held until flush_done_o.
- flush_done_o  out  1  one-cycle pulse when flush completes.
- stall_o  out  1  stall the upstream pipeline, so there is no tl read next cycle.
- dmem_v_o  out  1  data SRAM write strobe.
- dmem_addr_o  out  10  SRAM row {set_index, word_offset} = addr[12:3].
- dmem_data_o  out  512  store data replicated ways_p times.
- dmem_mask_o  out  64  byte write mask, placed at the way_id lane.

Behaviour:
- Clock and reset (already decided): single clock clk_i; reset_i is asynchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, stall_o=0, flush_done_o=0. While reset_i is high, dmem_v_o=0 and sbuf_yumi_o=0.
- Drain condition: drain = sbuf_v_i & ~tl_dmem_v_i & ~reset_i.
  - dmem_v_o = drain and sbuf_yumi_o = drain, both combinational, zero-latency.
  - The entry is popped in the same cycle the write is issued.
- Write datapath:
  - dmem_addr_o = addr[3+log2(sets_p*block_size_in_words_p)-1:3].
  - dmem_data_o = {ways_p{data}}.
  - dmem_mask_o = mask << (8*way_id); all other lanes are 0.
  - With dmem_v_o=0, these outputs are don't-care.
- Starvation counter (starve_cnt, log2(starve_limit_p)+1 bits):
  - Increments when sbuf_v_i & tl_dmem_v_i & ~stall_o.
  - Clears when drain occurs or sbuf_v_i=0.
  - Saturates at starve_limit_p.
- State machine states: IDLE, FORCE, FLUSH, DONE.
- IDLE:
  - Go to FLUSH if flush_i.
  - Else go to FORCE when starve_cnt reaches starve_limit_p.
- FORCE:
  - stall_o=1 (registered; asserted the cycle after the threshold).
  - Return to IDLE the cycle after a drain occurs.
  - If flush_i rises while in FORCE, go to FLUSH once that drain completes.
- FLUSH:
  - stall_o=1 for the whole state.
  - Drain whenever sbuf_v_i.
  - Go to DONE when sbuf_empty_i=1 and no drain occurs this cycle.
- DONE: flush_done_o=1 for exactly one cycle, then go to IDLE. The requester drops flush_i on seeing flush_done_o.
- Boundary cases:
  - flush_i while already empty: FLUSH lasts 1 cycle, then DONE, so the flush_done_o pulse comes 2 cycles after request.
  - tl_dmem_v_i asserted despite stall_o: tl still wins. starve_cnt holds; stall_o is not re-evaluated.
  - Reset mid-FLUSH: returns to IDLE with no done pulse.

Decomposition:
- Package bsg_cache_pkg holds:
  - the sbuf entry struct {addr, data, mask, way_id} with widths derived from the parameters;
  - the state enum;
  - a function for the SRAM row-address width.
- One sub-module, bsg_cache_sbuf_drain_expand, is purely combinational: it takes way_id, data and mask and produces the replicated dmem_data and lane-shifted dmem_mask.
- The FSM and starve counter stay in the top module.

Test Plan:
- Plain drain: one entry, addr=0x00_0000_1238, data=0xDEADBEEF_CAFEF00D, mask=0xFF, way_id=5; tl idle.
  - Same cycle: dmem_v_o=1, sbuf_yumi_o=1, dmem_addr_o=0x247.
  - dmem_mask_o=0x0000FF00_00000000; dmem_data_o = data replicated.
- Priority: sbuf_v_i=1 and tl_dmem_v_i=1 for 3 cycles.
  - dmem_v_o=0 and sbuf_yumi_o=0 each cycle; starve_cnt=3.
  - tl drops on cycle 4 → drain; starve_cnt returns to 0.
- Starvation: tl_dmem_v_i held high and sbuf_v_i=1.
  - stall_o=1 from cycle 5 (after limit 4).
  - When tl is released the drain happens, and stall_o=0 the following cycle.
- Flush with 2 entries, tl idle:
  - Drains on cycles 1 and 2; flush_done_o pulses on cycle 4.
  - stall_o=1 from cycle 1 through 3.
- Flush while empty: flush_done_o pulses exactly 2 cycles after flush_i rises; no dmem_v_o.
- Async reset asserted mid-FLUSH:
  - stall_o=0 and flush_done_o=0 immediately, without waiting for a clock edge.
  - No done pulse after reset deasserts.
